// File: rtl/billiard_pkg.sv
// Shared types and constants for the billiard game sequencer and its helpers.
package billiard_pkg;

  localparam int NUM_BALLS = 11;
  localparam int CUE_IDX   = 0;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [2:0] {
    S_TITLE,
    S_AIM,
    S_ROLL,
    S_SETTLE,
    S_WIN,
    S_LOSE
  } game_state_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t units;
  } bcd2_t;

  // Two-digit BCD decrement that sticks at 00 instead of wrapping to 99.
  function automatic bcd2_t bcd_dec(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.units != 4'd0) begin
      r.units = v.units - 4'd1;
    end else if (v.tens != 4'd0) begin
      r.units = 4'd9;
      r.tens  = v.tens - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit saturating BCD down counter holding the remaining strike budget.
module bcd_down_counter
  import billiard_pkg::*;
#(
  parameter int unsigned INIT_TENS  = 1,
  parameter int unsigned INIT_UNITS = 5
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       load_i,
  input  logic       dec_i,
  output bcd_digit_t tens_o,
  output bcd_digit_t units_o,
  output logic       is_zero_o
);

  localparam bcd2_t INIT_VAL = '{tens: 4'(INIT_TENS), units: 4'(INIT_UNITS)};

  bcd2_t cnt_q, cnt_d;

  // Load has priority over decrement; otherwise hold.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = INIT_VAL;
    end else if (dec_i) begin
      cnt_d = bcd_dec(cnt_q);
    end
  end

  // Counter register, reset to the initial strike budget.
  always_ff @(posedge clk or negedge resetN) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample the same edge.
    if (!resetN) begin
      cnt_q <= INIT_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tens_o    = cnt_q.tens;
  assign units_o   = cnt_q.units;
  assign is_zero_o = (cnt_q.tens == 4'd0) && (cnt_q.units == 4'd0);

endmodule

// File: rtl/game_flow_controller.sv
// Frame-synchronous game sequencer: title, aim, roll, settle and end phases,
// cue-stick gating, strike budget and sticky pocket flags.
module game_flow_controller
  import billiard_pkg::*;
#(
  parameter int unsigned STRIKES_INIT_TENS  = 1,
  parameter int unsigned STRIKES_INIT_UNITS = 5,
  parameter int unsigned SETTLE_FRAMES      = 8,
  parameter int unsigned END_FRAMES         = 180
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 start_frame,
  input  logic                 key_start,
  input  logic                 key_shoot,
  input  logic                 balls_moving,
  input  logic [NUM_BALLS-1:0] ball_in_pocket,
  output logic                 game_state,
  output logic                 stick_enable,
  output logic                 shot_strobe,
  output logic                 respot_cue,
  output logic [NUM_BALLS-1:0] pocketed_mask,
  output bcd_digit_t           strikes_tens,
  output bcd_digit_t           strikes_units,
  output logic                 win,
  output logic                 lose
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_FRAMES - 1);
  localparam logic [9:0] END_LAST    = 10'(END_FRAMES - 1);

  game_state_t          state_q, state_d;
  logic [7:0]           settle_cnt_q, settle_cnt_d;
  logic [9:0]           end_cnt_q, end_cnt_d;
  logic [NUM_BALLS-1:0] mask_q, mask_d, mask_now;
  logic                 key_start_q, key_shoot_q;
  logic                 start_edge, shoot_edge;
  logic                 strikes_load, strikes_dec, strikes_zero, strikes_one;
  logic                 fire_shot, do_respot;
  logic                 game_state_q, stick_enable_q, shot_strobe_q, respot_cue_q;
  logic                 win_q, lose_q;

  assign start_edge = key_start & ~key_start_q;
  assign shoot_edge = key_shoot & ~key_shoot_q;
  assign mask_now   = mask_q | ball_in_pocket;
  assign strikes_one = (strikes_tens == 4'd0) && (strikes_units == 4'd1);

  bcd_down_counter #(
    .INIT_TENS  (STRIKES_INIT_TENS),
    .INIT_UNITS (STRIKES_INIT_UNITS)
  ) u_strikes (
    .clk       (clk),
    .resetN    (resetN),
    .load_i    (strikes_load),
    .dec_i     (strikes_dec),
    .tens_o    (strikes_tens),
    .units_o   (strikes_units),
    .is_zero_o (strikes_zero)
  );

  // Next-state, counters, pocket mask and strike control for the game phases.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    end_cnt_d    = end_cnt_q;
    mask_d       = mask_q;
    strikes_load = 1'b0;
    strikes_dec  = 1'b0;
    fire_shot    = 1'b0;
    do_respot    = 1'b0;
    unique case (state_q)
      S_TITLE: begin
        if (start_edge) begin
          state_d      = S_AIM;
          strikes_load = 1'b1;
          mask_d       = '0;
        end
      end
      S_AIM: begin
        // Start edges are ignored here, so a simultaneous start never blocks a shot.
        if (shoot_edge && !strikes_zero) begin
          fire_shot   = 1'b1;
          strikes_dec = 1'b1;
          state_d     = S_ROLL;
        end
      end
      S_ROLL: begin
        mask_d = mask_now;
        if (start_frame && !balls_moving) begin
          state_d      = S_SETTLE;
          settle_cnt_d = '0;
        end
      end
      S_SETTLE: begin
        mask_d = mask_now;
        if (balls_moving) begin
          state_d = S_ROLL;
        end else if (start_frame) begin
          if (settle_cnt_q == SETTLE_LAST) begin
            end_cnt_d = '0;
            if (&mask_now[NUM_BALLS-1:1]) begin
              // Clearing the table wins even if the cue ball also dropped.
              state_d = S_WIN;
            end else begin
              if (mask_now[CUE_IDX]) begin
                do_respot       = 1'b1;
                strikes_dec     = 1'b1;
                mask_d[CUE_IDX] = 1'b0;
              end
              // Judge against the budget as it will be after any scratch penalty.
              if (strikes_zero || (do_respot && strikes_one)) begin
                state_d = S_LOSE;
              end else begin
                state_d = S_AIM;
              end
            end
          end else begin
            settle_cnt_d = settle_cnt_q + 8'd1;
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (start_frame) begin
          if (end_cnt_q == END_LAST) begin
            state_d = S_TITLE;
          end else begin
            end_cnt_d = end_cnt_q + 10'd1;
          end
        end
      end
      default: state_d = S_TITLE;
    endcase
  end

  // Phase state, counters, pocket flags and key history.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= S_TITLE;
      settle_cnt_q <= '0;
      end_cnt_q    <= '0;
      mask_q       <= '0;
      key_start_q  <= 1'b0;
      key_shoot_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      end_cnt_q    <= end_cnt_d;
      mask_q       <= mask_d;
      key_start_q  <= key_start;
      key_shoot_q  <= key_shoot;
    end
  end

  // Registered outputs decoded from the upcoming state so they line up with it.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      game_state_q   <= 1'b0;
      stick_enable_q <= 1'b0;
      shot_strobe_q  <= 1'b0;
      respot_cue_q   <= 1'b0;
      win_q          <= 1'b0;
      lose_q         <= 1'b0;
    end else begin
      game_state_q   <= (state_d != S_TITLE);
      stick_enable_q <= (state_d == S_AIM);
      shot_strobe_q  <= fire_shot;
      respot_cue_q   <= do_respot;
      win_q          <= (state_d == S_WIN);
      lose_q         <= (state_d == S_LOSE);
    end
  end

  assign game_state    = game_state_q;
  assign stick_enable  = stick_enable_q;
  assign shot_strobe   = shot_strobe_q;
  assign respot_cue    = respot_cue_q;
  assign pocketed_mask = mask_q;
  assign win           = win_q;
  assign lose          = lose_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller; shot/respot pulses are checked by a
// scoreboard monitor, level outputs by direct checks at quiet points.
module tb_game_flow_controller;
  import billiard_pkg::*;

  typedef enum {EV_SHOT, EV_RESPOT} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int          strikes;
    logic [10:0] mask;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  mdl_strikes;
  logic [10:0] mdl_mask;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        start_frame = 1'b0;
  logic        key_start = 1'b0;
  logic        key_shoot = 1'b0;
  logic        balls_moving = 1'b0;
  logic [10:0] ball_in_pocket = '0;
  logic        game_state, stick_enable, shot_strobe, respot_cue, win, lose;
  logic [10:0] pocketed_mask;
  bcd_digit_t  strikes_tens, strikes_units;

  always #5 clk = ~clk;

  game_flow_controller dut (
    .clk            (clk),
    .resetN         (resetN),
    .start_frame    (start_frame),
    .key_start      (key_start),
    .key_shoot      (key_shoot),
    .balls_moving   (balls_moving),
    .ball_in_pocket (ball_in_pocket),
    .game_state     (game_state),
    .stick_enable   (stick_enable),
    .shot_strobe    (shot_strobe),
    .respot_cue     (respot_cue),
    .pocketed_mask  (pocketed_mask),
    .strikes_tens   (strikes_tens),
    .strikes_units  (strikes_units),
    .win            (win),
    .lose           (lose)
  );

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      start_frame = 1'b1;
      tick(1);
      start_frame = 1'b0;
      tick(3);
    end
  endtask

  task automatic press_start();
    key_start = 1'b1;
    tick(1);
    key_start = 1'b0;
    tick(2);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_game_state"}, game_state, 0);
    check({tag, "_stick_enable"}, stick_enable, 0);
    check({tag, "_shot_strobe"}, shot_strobe, 0);
    check({tag, "_respot_cue"}, respot_cue, 0);
    check({tag, "_mask"}, pocketed_mask, 0);
    check({tag, "_strikes"}, {strikes_tens, strikes_units}, to_bcd(15));
    check({tag, "_win"}, win, 0);
    check({tag, "_lose"}, lose, 0);
  endtask

  // One full shot: fire, roll with optional pocket events, settle, evaluate.
  task automatic take_shot(input logic [10:0] pockets, input bit with_start, input bit interrupt);
    logic win_exp;
    mdl_strikes--;
    exp_q.push_back('{EV_SHOT, mdl_strikes, mdl_mask});
    key_shoot = 1'b1;
    key_start = with_start;
    tick(1);
    key_shoot = 1'b0;
    key_start = 1'b0;
    tick(2);
    check("roll_stick_off", stick_enable, 0);
    check("roll_game_state", game_state, 1);
    balls_moving   = 1'b1;
    ball_in_pocket = pockets;
    tick(1);
    ball_in_pocket = '0;
    mdl_mask = mdl_mask | pockets;
    win_exp  = &mdl_mask[10:1];
    if (!win_exp && mdl_mask[0]) begin
      mdl_mask[0] = 1'b0;
      if (mdl_strikes > 0) mdl_strikes--;
      exp_q.push_back('{EV_RESPOT, mdl_strikes, mdl_mask});
    end
    frames(2);
    balls_moving = 1'b0;
    if (interrupt) begin
      frames(5);
      balls_moving = 1'b1;
      frames(1);
      balls_moving = 1'b0;
      frames(4);
      check("settle_restarted", stick_enable, 0);
    end
    frames(10);
    @(negedge clk);
    check("shot_mask", pocketed_mask, mdl_mask);
    check("shot_strikes", {strikes_tens, strikes_units}, to_bcd(mdl_strikes));
    if (win_exp) check("shot_win", win, 1);
    else if (mdl_strikes == 0) check("shot_lose", lose, 1);
    else check("shot_back_in_aim", stick_enable, 1);
  endtask

  // Scoreboard monitor: every strobe or respot pulse must match the next expected event.
  always @(negedge clk) begin
    if (resetN && (shot_strobe || respot_cue)) begin
      ev_t e;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: shot=%0b respot=%0b, expected none", shot_strobe, respot_cue);
      end else begin
        e = exp_q.pop_front();
        check(e.kind == EV_SHOT ? "shot_pulse" : "respot_pulse", {shot_strobe, respot_cue},
              e.kind == EV_SHOT ? 2'b10 : 2'b01);
        check("pulse_strikes", {strikes_tens, strikes_units}, to_bcd(e.strikes));
        check("pulse_mask", pocketed_mask, e.mask);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mdl_strikes = 15;
    mdl_mask    = '0;
    tick(2);
    @(negedge clk);
    check_reset_values("reset");
    resetN = 1'b1;
    tick(2);
    check("title_game_state", game_state, 0);

    press_start();
    check("aim_game_state", game_state, 1);
    check("aim_stick", stick_enable, 1);
    check("aim_strikes", {strikes_tens, strikes_units}, to_bcd(15));

    take_shot(11'h004, 1'b0, 1'b0);            // 15 -> 14, object ball 2 kept

    press_start();                             // start ignored while aiming
    check("start_ignored_strikes", {strikes_tens, strikes_units}, to_bcd(14));
    check("start_ignored_mask", pocketed_mask, 11'h004);

    take_shot(11'h000, 1'b1, 1'b0);            // shoot beats simultaneous start: 13
    repeat (3) take_shot(11'h000, 1'b0, 1'b0); // 12, 11, 10
    take_shot(11'h001, 1'b0, 1'b0);            // scratch from 10: 09 then 08
    take_shot(11'h000, 1'b0, 1'b1);            // settle interrupted: 07
    while (mdl_strikes > 1) take_shot(11'h000, 1'b0, 1'b0);
    take_shot(11'h001, 1'b0, 1'b0);            // last strike plus scratch: stays 00

    check("lose_game_state", game_state, 1);
    check("lose_stick", stick_enable, 0);
    key_shoot = 1'b1;
    key_start = 1'b1;
    tick(1);
    key_shoot = 1'b0;
    key_start = 1'b0;
    tick(2);
    check("lose_keys_ignored", {strikes_tens, strikes_units}, to_bcd(0));
    frames(170);
    check("lose_held", lose, 1);
    frames(15);
    check("end_title_game_state", game_state, 0);
    check("end_title_lose", lose, 0);
    check("end_title_stick", stick_enable, 0);

    press_start();
    mdl_strikes = 15;
    mdl_mask    = '0;
    check("reload_strikes", {strikes_tens, strikes_units}, to_bcd(15));
    check("reload_mask", pocketed_mask, 0);
    take_shot(11'h7FF, 1'b0, 1'b0);            // all balls plus cue: win, no respot
    check("win_stick", stick_enable, 0);
    check("win_lose_low", lose, 0);

    resetN = 1'b0;
    tick(1);
    resetN = 1'b1;
    tick(1);
    press_start();
    mdl_strikes = 15;
    mdl_mask    = '0;
    exp_q.push_back('{EV_SHOT, 14, 11'h000});
    key_shoot = 1'b1;
    tick(1);
    key_shoot = 1'b0;
    tick(2);
    balls_moving   = 1'b1;
    ball_in_pocket = 11'h002;
    tick(1);
    ball_in_pocket = '0;
    check("midroll_mask", pocketed_mask, 11'h002);
    #2 resetN = 1'b0;
    #1 check_reset_values("async_reset");
    balls_moving = 1'b0;
    tick(2);
    resetN = 1'b1;
    tick(2);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
